// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window feeder: FSM encoding and sizing helpers.
package conv_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  localparam int MAC_LAT_DEF = 2;

  function automatic int taps(input int k);
    return k * k;
  endfunction
endpackage

// File: rtl/conv_window_feeder_if.sv
// Result channel from the window feeder to the layer controller.
interface conv_window_feeder_if #(parameter int BIT = 8);
  logic           result_valid;
  logic [BIT-1:0] result_data;
  logic           result_ready;

  modport master (output result_valid, output result_data, input result_ready);
  modport slave  (input result_valid, input result_data, output result_ready);
endinterface

// File: rtl/window_addr_gen.sv
// Tap counters for one KSIZE x KSIZE window and the matching image/weight SRAM addresses.
module window_addr_gen
  import conv_pkg::*;
#(
  parameter int KSIZE   = 3,
  parameter int IMG_W   = 28,
  parameter int ADDR_W  = 10,
  parameter int WADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic [ADDR_W-1:0]  base,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [WADDR_W-1:0] wgt_addr,
  output logic               last_tap
);
  localparam int KW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int NTAPS = taps(KSIZE);

  logic [KW-1:0] kx, ky;
  logic          kx_last;

  assign kx_last  = (kx == KW'(KSIZE-1));
  assign last_tap = (wgt_addr == WADDR_W'(NTAPS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0;
      ky <= '0;
    end else if (clr) begin
      kx <= '0;
      ky <= '0;
    end else if (inc) begin
      if (kx_last) begin
        kx <= '0;
        ky <= (ky == KW'(KSIZE-1)) ? '0 : ky + 1'b1;
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

  // Truncation to ADDR_W gives the intended modulo wrap of the image address.
  assign pix_addr = base + ADDR_W'(ky) * ADDR_W'(IMG_W) + ADDR_W'(kx);
  assign wgt_addr = WADDR_W'(ky) * WADDR_W'(KSIZE) + WADDR_W'(kx);
endmodule

// File: rtl/conv_window_feeder.sv
// Reads one pixel/weight window, streams it into the MAC and returns the drained result.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int BIT     = 8,
  parameter int KSIZE   = 3,
  parameter int IMG_W   = 28,
  parameter int ADDR_W  = 10,
  parameter int WADDR_W = 4,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [1:0]         norm_mode,
  output logic               busy,
  output logic               pix_rd_en,
  output logic [ADDR_W-1:0]  pix_addr,
  input  logic [BIT-1:0]     pix_rdata,
  output logic               wgt_rd_en,
  output logic [WADDR_W-1:0] wgt_addr,
  input  logic [BIT-1:0]     wgt_rdata,
  output logic [BIT-1:0]     picture,
  output logic [BIT-1:0]     weight,
  output logic               accumulator_en,
  output logic               acc_clear,
  output logic [1:0]         normalizer_mode,
  input  logic [BIT-1:0]     conv_result,
  conv_window_feeder_if.master res
);
  localparam int STAGES = 1;
  localparam int DW     = $clog2(MAC_LAT + 2);

  state_t              state, nxt;
  logic [STAGES:0]     vld_pipe;
  logic [ADDR_W-1:0]   base_q;
  logic [DW-1:0]       drain_cnt;
  logic                issue, last_q, last_tap, drain_done;
  logic [ADDR_W-1:0]   gen_pix;
  logic [WADDR_W-1:0]  gen_wgt;

  window_addr_gen #(.KSIZE(KSIZE), .IMG_W(IMG_W), .ADDR_W(ADDR_W), .WADDR_W(WADDR_W)) u_addr (
    .clk(clk), .rst_n(rst_n), .clr(state == ST_IDLE), .inc(issue),
    .base(base_q), .pix_addr(gen_pix), .wgt_addr(gen_wgt), .last_tap(last_tap)
  );

  assign drain_done = (state == ST_DRAIN) && (drain_cnt == DW'(MAC_LAT));

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start) nxt = ST_CLEAR;
      ST_CLEAR:  nxt = ST_FETCH;
      ST_FETCH:  if (last_q) nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_done) nxt = ST_RESULT;
      ST_RESULT: if (res.result_ready) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Reads are issued one cycle ahead so the registered address lines up with FETCH.
  assign issue = (nxt == ST_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      acc_clear       <= 1'b0;
      vld_pipe        <= '0;
      last_q          <= 1'b0;
      pix_addr        <= '0;
      wgt_addr        <= '0;
      base_q          <= '0;
      normalizer_mode <= '0;
      drain_cnt       <= '0;
      res.result_valid <= 1'b0;
      res.result_data  <= '0;
    end else begin
      state       <= nxt;
      busy        <= (nxt != ST_IDLE);
      acc_clear   <= (nxt == ST_CLEAR);
      vld_pipe    <= {vld_pipe[STAGES-1:0], issue};
      last_q      <= issue & last_tap;
      drain_cnt   <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (issue) begin
        pix_addr <= gen_pix;
        wgt_addr <= gen_wgt;
      end
      if (state == ST_IDLE && start) begin
        base_q          <= base_addr;
        normalizer_mode <= norm_mode;
      end
      if (drain_done) begin
        res.result_valid <= 1'b1;
        res.result_data  <= conv_result;
      end else if (state == ST_RESULT && res.result_ready) begin
        res.result_valid <= 1'b0;
      end
    end
  end

  assign pix_rd_en      = vld_pipe[0];
  assign wgt_rd_en      = vld_pipe[0];
  assign accumulator_en = vld_pipe[STAGES];
  assign picture        = pix_rdata;
  assign weight         = wgt_rdata;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: table and random windows against a closed-form timing model.
module tb_conv_window_feeder;
  localparam int BIT = 8, KSIZE = 3, IMG_W = 28, ADDR_W = 10, WADDR_W = 4, MAC_LAT = 2;
  localparam int NT    = KSIZE * KSIZE;
  localparam int T_RD  = 2;                 // first read cycle after start
  localparam int T_VAL = NT + MAC_LAT + 3;  // first result_valid cycle

  logic clk = 0, rst_n = 0;
  logic start = 0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [1:0] norm_mode = '0;
  logic busy, pix_rd_en, wgt_rd_en, accumulator_en, acc_clear;
  logic [ADDR_W-1:0] pix_addr;
  logic [WADDR_W-1:0] wgt_addr;
  logic [BIT-1:0] pix_rdata = '0, wgt_rdata = '0, picture, weight, conv_result = '0;
  logic [1:0] normalizer_mode;

  conv_window_feeder_if #(.BIT(BIT)) res_if ();

  conv_window_feeder #(.BIT(BIT), .KSIZE(KSIZE), .IMG_W(IMG_W), .ADDR_W(ADDR_W),
                       .WADDR_W(WADDR_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .norm_mode(norm_mode),
    .busy(busy), .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_rdata(pix_rdata),
    .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
    .picture(picture), .weight(weight), .accumulator_en(accumulator_en),
    .acc_clear(acc_clear), .normalizer_mode(normalizer_mode), .conv_result(conv_result),
    .res(res_if)
  );

  always #5 clk = ~clk;

  logic [BIT-1:0] pix_mem [1024];
  logic [BIT-1:0] wgt_mem [16];

  always @(posedge clk) begin
    if (pix_rd_en) pix_rdata <= pix_mem[pix_addr];
    if (wgt_rd_en) wgt_rdata <= wgt_mem[wgt_addr];
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, exp);
    end
  endtask

  // Image address of tap t: row-major walk of the window, modulo the SRAM size.
  function automatic logic [ADDR_W-1:0] eaddr(input logic [ADDR_W-1:0] b, input int t);
    int v;
    v = (int'(b) + (t / KSIZE) * IMG_W + (t % KSIZE)) % (1 << ADDR_W);
    return ADDR_W'(v);
  endfunction

  task automatic chk_zero(input int c);
    chk("rst_busy", c, busy, 0);
    chk("rst_pix_rd_en", c, pix_rd_en, 0);
    chk("rst_wgt_rd_en", c, wgt_rd_en, 0);
    chk("rst_pix_addr", c, pix_addr, 0);
    chk("rst_wgt_addr", c, wgt_addr, 0);
    chk("rst_acc_en", c, accumulator_en, 0);
    chk("rst_acc_clear", c, acc_clear, 0);
    chk("rst_norm", c, normalizer_mode, 0);
    chk("rst_valid", c, res_if.result_valid, 0);
    chk("rst_data", c, res_if.result_data, 0);
  endtask

  // Called just after a rising edge with the DUT idle; cycle 0 is the start cycle.
  task automatic run_window(input logic [ADDR_W-1:0] b, input logic [1:0] nm,
                            input logic [BIT-1:0] rv, input int dly, input bit extra);
    int last = T_VAL + dly + 1;
    for (int c = 0; c <= last; c++) begin
      start        = (c == 0) || (extra && (c == 4 || c == 12));
      base_addr    = (c == 0) ? b : ADDR_W'($urandom);
      norm_mode    = (c == 0) ? nm : 2'($urandom);
      conv_result  = (c == T_VAL - 1) ? rv : ~rv;
      res_if.result_ready = (c == T_VAL + dly) ? 1'b1 : (c < T_VAL - 1) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      chk("busy", c, busy, (c >= 1 && c <= T_VAL + dly));
      chk("acc_clear", c, acc_clear, (c == 1));
      chk("pix_rd_en", c, pix_rd_en, (c >= T_RD && c < T_RD + NT));
      chk("wgt_rd_en", c, wgt_rd_en, (c >= T_RD && c < T_RD + NT));
      if (c >= T_RD && c < T_RD + NT) begin
        chk("pix_addr", c, pix_addr, eaddr(b, c - T_RD));
        chk("wgt_addr", c, wgt_addr, c - T_RD);
      end
      chk("acc_en", c, accumulator_en, (c >= T_RD + 1 && c < T_RD + 1 + NT));
      if (c >= T_RD + 1 && c < T_RD + 1 + NT) begin
        chk("picture", c, picture, pix_mem[eaddr(b, c - T_RD - 1)]);
        chk("weight", c, weight, wgt_mem[c - T_RD - 1]);
      end
      if (c >= 1) chk("norm_mode", c, normalizer_mode, nm);
      chk("result_valid", c, res_if.result_valid, (c >= T_VAL && c <= T_VAL + dly));
      if (c >= T_VAL && c <= T_VAL + dly) chk("result_data", c, res_if.result_data, rv);
      @(posedge clk); #1;
    end
    start = 0;
    res_if.result_ready = 0;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [1:0]        nm;
    logic [BIT-1:0]    rv;
    int                dly;
    bit                extra;
  } vec_t;

  vec_t tbl [$];

  initial begin
    for (int i = 0; i < 1024; i++) pix_mem[i] = BIT'($urandom);
    for (int i = 0; i < 16; i++) wgt_mem[i] = BIT'($urandom);
    res_if.result_ready = 0;

    #2;
    chk_zero(-1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    tbl.push_back('{base: 10'd0,    nm: 2'b10, rv: 8'hA5, dly: 5, extra: 1'b0});
    tbl.push_back('{base: 10'd0,    nm: 2'b10, rv: 8'hA5, dly: 5, extra: 1'b1});
    tbl.push_back('{base: 10'd1020, nm: 2'b01, rv: 8'h3C, dly: 0, extra: 1'b0});
    tbl.push_back('{base: 10'd1023, nm: 2'b11, rv: 8'hFF, dly: 1, extra: 1'b1});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{base: ADDR_W'($urandom), nm: 2'($urandom), rv: BIT'($urandom),
                      dly: int'($urandom_range(0, 6)), extra: 1'($urandom)});

    for (int i = 0; i < tbl.size(); i++)
      run_window(tbl[i].base, tbl[i].nm, tbl[i].rv, tbl[i].dly, tbl[i].extra);

    // Reset in the middle of FETCH, then a clean window from base 100.
    start = 1; base_addr = 10'd50; norm_mode = 2'b11;
    @(posedge clk); #1;
    start = 0;
    for (int c = 2; c <= 6; c++) begin @(posedge clk); #1; end
    chk("pre_rst_rd_en", 6, pix_rd_en, 1);
    rst_n = 0; #1;
    chk_zero(6);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk_zero(7);
    run_window(10'd100, 2'b01, 8'h5A, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Initiator side of the convolution MAC datapath.
- On `start`, reads one KSIZE x KSIZE pixel window from image SRAM and the matching weights from weight SRAM (both synchronous-read, 1-cycle latency).
- Streams the operand pairs into the MAC's `picture`/`weight` inputs with `accumulator_en` aligned to the data, clears the accumulator before each window, and captures `conv_result` after the MAC pipeline drains.
- Returns the captured result over a valid/ready handshake to the layer controller.

Parameters:
- BIT, 8, pixel/weight/result width; must match the MAC.
- KSIZE, 3, kernel edge length; window has KSIZE*KSIZE taps.
- IMG_W, 28, image row pitch in pixels.
- ADDR_W, 10, image SRAM address width.
- WADDR_W, 4, weight SRAM address width; must satisfy 2^WADDR_W >= KSIZE*KSIZE.
- MAC_LAT, 2, cycles from the last enabled accumulate to a valid `conv_result`.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one window; sampled only in IDLE
- base_addr  in  ADDR_W  image address of the window's top-left pixel
- norm_mode  in  2  normalizer mode; latched at start
- busy  out  1  high in every state except IDLE
- pix_rd_en  out  1  image SRAM read enable
- pix_addr  out  ADDR_W  image SRAM address
- pix_rdata  in  BIT  image SRAM read data, valid the cycle after pix_rd_en
- wgt_rd_en  out  1  weight SRAM read enable; identical to pix_rd_en
- wgt_addr  out  WADDR_W  weight SRAM address
- wgt_rdata  in  BIT  weight SRAM read data
- picture  out  BIT  to MAC; combinational pass-through of pix_rdata
- weight  out  BIT  to MAC; combinational pass-through of wgt_rdata
- accumulator_en  out  1  to MAC; pix_rd_en delayed by 1 cycle
- acc_clear  out  1  to MAC accumulator synchronous clear
- normalizer_mode  out  2  to MAC; the latched norm_mode
- conv_result  in  BIT  from MAC (registered output)
- result_valid  out  1  captured result available
- result_data  out  BIT  captured result
- result_ready  in  1  consumer accepts result

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE and tap counters clear.
  - All registered outputs go to 0: busy, rd_en, addresses, accumulator_en, acc_clear, normalizer_mode, result_valid, result_data.
  - An in-flight window is discarded with no partial result.
- FSM states: IDLE, CLEAR, FETCH, DRAIN, RESULT.
- IDLE:
  - start=1 latches base_addr and norm_mode, then moves to CLEAR.
  - start in any other state is ignored, not queued.
- CLEAR (1 cycle): acc_clear=1, then FETCH.
- FETCH (KSIZE*KSIZE cycles):
  - Tap counters kx (inner) and ky (outer) run 0..KSIZE-1.
  - pix_rd_en=wgt_rd_en=1.
  - pix_addr = (base + ky*IMG_W + kx) mod 2^ADDR_W, i.e. wraps with no error.
  - wgt_addr = ky*KSIZE + kx.
  - After the last tap, move to DRAIN.
- Operand alignment: accumulator_en is high exactly KSIZE*KSIZE consecutive cycles, starting one cycle after the first read.
- DRAIN (MAC_LAT+1 cycles): no reads issued. On the final DRAIN edge, result_data <= conv_result, result_valid <= 1, and the FSM moves to RESULT.
- RESULT:
  - result_valid and result_data are held stable until result_ready=1.
  - On handshake, result_valid drops and the FSM returns to IDLE on the next cycle.
  - A new start is accepted only in IDLE, so minimum issue interval is KSIZE*KSIZE+MAC_LAT+4 cycles.
- Latency: start sampled in cycle 0; result_valid first high in cycle KSIZE*KSIZE+MAC_LAT+3. Defaults give cycle 14.
- Fixed ownership:
  - Accumulator overflow and normalizer validity belong to the MAC; the feeder does not inspect data.
  - acc_clear always precedes the first accumulator_en of each window.

Decomposition:
- Shared package `conv_pkg`: FSM state encoding (3-bit enum), MAC_LAT default, tap count KSIZE*KSIZE as a localparam function.
- One sub-module, `window_addr_gen`: kx/ky counters with increment/clear, last_tap flag, pix_addr/wgt_addr computation. The FSM and alignment/capture registers stay in the top.

Test Plan:
- Defaults, base_addr=0, start pulse in cycle 0:
  - pix_addr 0,1,2,28,29,30,56,57,58 in cycles 2..10; wgt_addr 0..8 in the same cycles.
  - acc_clear high in cycle 1 only; accumulator_en high in cycles 3..11.
- Stub MAC drives conv_result=8'hA5 in cycle 13 -> result_valid rises in cycle 14 with result_data=8'hA5; norm_mode=2'b10 latched -> normalizer_mode=2'b10 from cycle 1.
- result_ready held low 5 cycles after valid -> result_valid/result_data stable throughout; back in IDLE the cycle after ready=1; busy=0 there.
- start pulsed in cycles 4 and 12 -> ignored; address sequence and result timing are identical to the first scenario.
- rst_n low during cycle 6 (mid-FETCH) -> all outputs 0 immediately; a new start with base_addr=100 yields pix_addr 100,101,102,128,… and one correct result.
- base_addr=1020, ADDR_W=10 -> pix_addr 1020,1021,1022,24,25,26,52,53,54 (mod-1024 wrap), with no stall or error.
